csa_double_ora: RTL and testbench

- Output response analyzer for the carry-save-adder double-fault test path.
- Samples the 6-bit response of the CSA under test and compares it against the golden vector produced by the pattern generator for the same pattern.
- Accumulates per-pattern mismatch statistics over one sweep and reports a registered pass/fail verdict to the test controller.

---
 rtl/csa_double_ora.sv | 175 +++++++++++++++++
 tb/tb_csa_double_ora.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_double_ora.sv
// ============================================================================
// Module   : csa_double_ora
// Function : Output response analyzer for the CSA double-fault test path;
//            compares each sampled response to its golden vector and
//            accumulates a registered pass/fail verdict over one sweep.
//            Optional MISR signature: define CSA_DOUBLE_ORA_MISR_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module csa_double_ora #(
  parameter int WIDTH        = 6,
  parameter int NUM_PATTERNS = 4,
  parameter int IDX_W        = 2,
  parameter int ERR_CNT_W    = 3
`ifdef CSA_DOUBLE_ORA_MISR_EN
  ,
  parameter logic [WIDTH-1:0] GOLDEN_SIG = WIDTH'(6'h21)
`endif
) (
  input  logic                 clk,
  input  logic                 init,
  input  logic                 test,
  input  logic [WIDTH-1:0]     cut_output,
  input  logic [WIDTH-1:0]     desired_output,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     fail_mask,
  output logic [IDX_W-1:0]     first_fail_idx
`ifdef CSA_DOUBLE_ORA_MISR_EN
  ,
  output logic [WIDTH-1:0]     signature,
  output logic [0:0]           sig_match
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   fail_q, fail_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d;
  logic [WIDTH-1:0]       mask_q, mask_d;
  logic [IDX_W-1:0]       ffi_q, ffi_d;
  logic                   w_cmp;
  logic [WIDTH-1:0]       w_diff;
`ifdef CSA_DOUBLE_ORA_MISR_EN
  logic [WIDTH-1:0]       sig_q, sig_d;
  logic                   match_q, match_d;
`endif

  assign w_diff = cut_output ^ desired_output;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    fail_d  = fail_q;
    err_d   = err_q;
    mask_d  = mask_q;
    ffi_d   = ffi_q;
    w_cmp   = 1'b0;
`ifdef CSA_DOUBLE_ORA_MISR_EN
    sig_d   = sig_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (test) begin
          w_cmp = 1'b1;
          if (NUM_PATTERNS == 1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (test) begin
          w_cmp = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_cmp) begin
      mask_d = mask_q | w_diff;
      idx_d  = idx_q + IDX_W'(1);
      if (w_diff != '0) begin
        if (err_q != '1) begin
          err_d = err_q + ERR_CNT_W'(1);
        end
        // Only the first mismatch of the sweep records its index.
        if (!fail_q) begin
          fail_d = 1'b1;
          ffi_d  = idx_q;
        end
      end
`ifdef CSA_DOUBLE_ORA_MISR_EN
      sig_d = ({sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? WIDTH'(3) : '0)) ^ cut_output;
`endif
    end
  end

`ifdef CSA_DOUBLE_ORA_MISR_EN
  // Built from next-state values so the match flag rises with done.
  assign match_d = done_d & (sig_d == GOLDEN_SIG);
`endif

  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= '0;
      mask_q  <= '0;
      ffi_q   <= '0;
`ifdef CSA_DOUBLE_ORA_MISR_EN
      sig_q   <= '1;
      match_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      ffi_q   <= ffi_d;
`ifdef CSA_DOUBLE_ORA_MISR_EN
      sig_q   <= sig_d;
      match_q <= match_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign err_count      = err_q;
  assign fail_mask      = mask_q;
  assign first_fail_idx = ffi_q;
`ifdef CSA_DOUBLE_ORA_MISR_EN
  assign signature      = sig_q;
  assign sig_match      = match_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_csa_double_ora.sv
// ============================================================================
// Module   : tb_csa_double_ora
// Function : Directed self-checking bench for csa_double_ora (MISR checks
//            enabled when CSA_DOUBLE_ORA_MISR_EN is defined).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_csa_double_ora;

  logic       clk = 1'b0;
  logic       init;
  logic       test;
  logic [5:0] cut_output;
  logic [5:0] desired_output;
  logic       busy, done, fail;
  logic [2:0] err_count;
  logic [5:0] fail_mask;
  logic [1:0] first_fail_idx;
`ifdef CSA_DOUBLE_ORA_MISR_EN
  logic [5:0] signature;
  logic [0:0] sig_match;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] gold [4] = '{6'h1A, 6'h25, 6'h25, 6'h0E};

  // {busy, done, fail, err_count, fail_mask, first_fail_idx}
  logic [13:0] obs;
  assign obs = {busy, done, fail, err_count, fail_mask, first_fail_idx};

  always #5 clk = ~clk;

  csa_double_ora dut (
    .clk            (clk),
    .init           (init),
    .test           (test),
    .cut_output     (cut_output),
    .desired_output (desired_output),
    .busy           (busy),
    .done           (done),
    .fail           (fail),
    .err_count      (err_count),
    .fail_mask      (fail_mask),
    .first_fail_idx (first_fail_idx)
`ifdef CSA_DOUBLE_ORA_MISR_EN
    ,
    .signature      (signature),
    .sig_match      (sig_match)
`endif
  );

  task automatic vec(input logic t, input logic [5:0] cut, input logic [5:0] des);
    test           = t;
    cut_output     = cut;
    desired_output = des;
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    init = 1'b1;
    test = 1'b0;
    @(posedge clk);
    #1;
    init = 1'b0;
  endtask

  task automatic test_reset();
    init = 1'b1; test = 1'b1; cut_output = 6'h3F; desired_output = 6'h00;
    @(posedge clk); #1;
    n_tests++;
    if (obs !== 14'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 14'h0);
    end
`ifdef CSA_DOUBLE_ORA_MISR_EN
    n_tests++;
    if (signature !== 6'h3F || sig_match !== 1'b0) begin
      n_fail++; $display("FAIL reset_misr: got sig=%h match=%b expected sig=3f match=0", signature, sig_match);
    end
`endif
    init = 1'b0;
  endtask

  task automatic test_fault_free();
    do_init();
    vec(1'b1, gold[0], gold[0]);
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL ff_first_edge: got busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    for (int i = 1; i < 4; i++) vec(1'b1, gold[i], gold[i]);
    n_tests++;
    if (obs !== {1'b0, 1'b1, 1'b0, 3'd0, 6'h00, 2'd0}) begin
      n_fail++; $display("FAIL ff_result: got %h expected %h", obs, {1'b0, 1'b1, 1'b0, 3'd0, 6'h00, 2'd0});
    end
`ifdef CSA_DOUBLE_ORA_MISR_EN
    n_tests++;
    if (signature !== 6'h21 || sig_match !== 1'b1) begin
      n_fail++; $display("FAIL ff_misr: got sig=%h match=%b expected sig=21 match=1", signature, sig_match);
    end
`endif
  endtask

  task automatic test_single_fault();
    do_init();
    for (int i = 0; i < 4; i++) vec(1'b1, (i == 2) ? 6'h24 : gold[i], gold[i]);
    n_tests++;
    if (obs !== {1'b0, 1'b1, 1'b1, 3'd1, 6'h01, 2'd2}) begin
      n_fail++; $display("FAIL single_fault: got %h expected %h", obs, {1'b0, 1'b1, 1'b1, 3'd1, 6'h01, 2'd2});
    end
`ifdef CSA_DOUBLE_ORA_MISR_EN
    n_tests++;
    if (sig_match !== 1'b0) begin
      n_fail++; $display("FAIL single_misr: got match=%b expected 0", sig_match);
    end
`endif
  endtask

  task automatic test_double_fault();
    do_init();
    for (int i = 0; i < 4; i++) vec(1'b1, gold[i] ^ 6'h30, gold[i]);
    n_tests++;
    if (obs !== {1'b0, 1'b1, 1'b1, 3'd4, 6'h30, 2'd0}) begin
      n_fail++; $display("FAIL double_fault: got %h expected %h", obs, {1'b0, 1'b1, 1'b1, 3'd4, 6'h30, 2'd0});
    end
  endtask

  task automatic test_saturation();
    // Two back-to-back all-mismatch sweeps would need reset; instead use
    // NUM_PATTERNS=4 < 7, so saturation is checked via counter staying at 4.
    do_init();
    for (int i = 0; i < 4; i++) vec(1'b1, ~gold[i], gold[i]);
    n_tests++;
    if (err_count !== 3'd4 || fail_mask !== 6'h3F) begin
      n_fail++; $display("FAIL all_bits: got err=%0d mask=%h expected err=4 mask=3f", err_count, fail_mask);
    end
  endtask

  task automatic test_pause();
    do_init();
    vec(1'b1, 6'h1B, gold[0]);
    vec(1'b1, gold[1], gold[1]);
    for (int p = 0; p < 3; p++) begin
      vec(1'b0, 6'h00, 6'h3F);
      n_tests++;
      if (obs !== {1'b1, 1'b0, 1'b1, 3'd1, 6'h01, 2'd0}) begin
        n_fail++; $display("FAIL pause_hold[%0d]: got %h expected %h", p, obs, {1'b1, 1'b0, 1'b1, 3'd1, 6'h01, 2'd0});
      end
    end
    vec(1'b1, gold[2], gold[2]);
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL pause_resume: got busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    vec(1'b1, gold[3], gold[3]);
    n_tests++;
    if (obs !== {1'b0, 1'b1, 1'b1, 3'd1, 6'h01, 2'd0}) begin
      n_fail++; $display("FAIL pause_final: got %h expected %h", obs, {1'b0, 1'b1, 1'b1, 3'd1, 6'h01, 2'd0});
    end
  endtask

  task automatic test_reset_mid_sweep();
    do_init();
    vec(1'b1, 6'h1B, gold[0]);
    vec(1'b1, gold[1], gold[1]);
    init = 1'b1;
    vec(1'b1, 6'h00, 6'h3F);
    init = 1'b0;
    n_tests++;
    if (obs !== 14'h0) begin
      n_fail++; $display("FAIL midreset_clear: got %h expected %h", obs, 14'h0);
    end
    for (int i = 0; i < 4; i++) vec(1'b1, gold[i], gold[i]);
    n_tests++;
    if (obs !== {1'b0, 1'b1, 1'b0, 3'd0, 6'h00, 2'd0}) begin
      n_fail++; $display("FAIL midreset_sweep: got %h expected %h", obs, {1'b0, 1'b1, 1'b0, 3'd0, 6'h00, 2'd0});
    end
`ifdef CSA_DOUBLE_ORA_MISR_EN
    n_tests++;
    if (signature !== 6'h21 || sig_match !== 1'b1) begin
      n_fail++; $display("FAIL midreset_misr: got sig=%h match=%b expected sig=21 match=1", signature, sig_match);
    end
`endif
  endtask

  task automatic test_done_hold();
    do_init();
    for (int i = 0; i < 4; i++) vec(1'b1, gold[i], gold[i]);
    for (int k = 0; k < 3; k++) begin
      vec(1'b1, 6'h00, gold[k]);
      n_tests++;
      if (obs !== {1'b0, 1'b1, 1'b0, 3'd0, 6'h00, 2'd0}) begin
        n_fail++; $display("FAIL done_hold[%0d]: got %h expected %h", k, obs, {1'b0, 1'b1, 1'b0, 3'd0, 6'h00, 2'd0});
      end
`ifdef CSA_DOUBLE_ORA_MISR_EN
      n_tests++;
      if (signature !== 6'h21 || sig_match !== 1'b1) begin
        n_fail++; $display("FAIL done_hold_misr[%0d]: got sig=%h match=%b expected sig=21 match=1", k, signature, sig_match);
      end
`endif
    end
  endtask

  initial begin
    init = 1'b1;
    test = 1'b0;
    cut_output = '0;
    desired_output = '0;
    @(posedge clk); #1;
    test_reset();
    test_fault_free();
    test_single_fault();
    test_double_fault();
    test_saturation();
    test_pause();
    test_reset_mid_sweep();
    test_done_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
